fetch_stage: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the 64-word combinational instruction memory.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_pc_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam pc_t    RESET_PC  = 6'd0;
    localparam instr_t NOP_WORD  = 32'h0007_8000;
    localparam instr_t HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
        logic   valid;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = {NOP_WORD, {PC_W{1'b0}}, 1'b0};

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with redirect/hold/increment mux and wrap pulse.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic redirect_i,
    input  pc_t  redirect_pc_i,
    input  logic advance_i,
    output pc_t  pc_o,
    output logic wrapped_o
);

    pc_t  pc_q;
    pc_t  pc_d;
    logic wrapped_q;
    logic wrapped_d;

    always_comb begin
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d      = pc_q + pc_t'(1);
            wrapped_d = (pc_q == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            wrapped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign pc_o      = pc_q;
    assign wrapped_o = wrapped_q;

endmodule : fetch_pc_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage: PC, IF/ID register, stall/redirect/flush.
//               Optional halt-on-HALT_WORD support with `define FETCH_HALT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   stall,
    input  logic   redirect_valid,
    input  pc_t    redirect_pc,
    output pc_t    count,
    input  instr_t instruction,
    output instr_t if_instr,
    output pc_t    if_pc,
    output logic   if_valid,
    output logic   wrapped,
    output logic   halted
);

    if_id_t if_id_q;
    if_id_t if_id_d;
    pc_t    pc;
    logic   is_halted;
    logic   do_redirect;
    logic   do_fetch;
    logic   halt_hit;
    logic   advance;

    assign do_redirect = redirect_valid && !is_halted;
    assign do_fetch    = !do_redirect && !is_halted && !stall && en;
    assign advance     = do_fetch && !halt_hit;

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic halted_d;

    assign halt_hit = do_fetch && (instruction == HALT_WORD);

    always_comb begin
        halted_d = halted_q | halt_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign is_halted = halted_q;
`else
    assign halt_hit  = 1'b0;
    assign is_halted = 1'b0;
`endif

    fetch_pc_reg u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (do_redirect),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc),
        .wrapped_o     (wrapped)
    );

    // if_pc is left untouched on flush/bubble; only valid entries carry meaning.
    always_comb begin
        if_id_d = if_id_q;
        if (do_redirect) begin
            if_id_d.instr = NOP_WORD;
            if_id_d.valid = 1'b0;
        end else if (is_halted) begin
            if_id_d.valid = 1'b0;
        end else if (stall) begin
            if_id_d = if_id_q;
        end else if (!en) begin
            if_id_d.valid = 1'b0;
        end else begin
            if_id_d.instr = instruction;
            if_id_d.pc    = pc;
            if_id_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q <= IF_ID_RESET;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign count    = pc;
    assign if_instr = if_id_q.instr;
    assign if_pc    = if_id_q.pc;
    assign if_valid = if_id_q.valid;
    assign halted   = is_halted;

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a cycle-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0007_8000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_pc = 6'd0;
    logic [5:0]  count;
    logic [31:0] instruction;
    logic [31:0] if_instr;
    logic [5:0]  if_pc;
    logic        if_valid;
    logic        wrapped;
    logic        halted;

    logic [31:0] mem [64];
    assign instruction = mem[count];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count),
        .instruction    (instruction),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .wrapped        (wrapped),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the spec's priority list applied to plain integers.
    int          m_pc;
    logic [31:0] m_instr;
    int          m_ifpc;
    bit          m_valid, m_wrap, m_halt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 0; m_wrap = 0; m_halt = 0;
        end else begin
            m_wrap = 0;
            if (redirect_valid && !m_halt) begin
                m_pc = int'(redirect_pc); m_valid = 0; m_instr = NOP;
            end else if (m_halt) begin
                m_valid = 0;
            end else if (stall) begin
                m_valid = m_valid;
            end else if (!en) begin
                m_valid = 0;
            end else begin
                m_instr = mem[m_pc]; m_ifpc = m_pc; m_valid = 1;
`ifdef FETCH_HALT_EN
                if (mem[m_pc] == HALT) m_halt = 1;
                else begin m_wrap = (m_pc == 63); m_pc = (m_pc + 1) % 64; end
`else
                m_wrap = (m_pc == 63); m_pc = (m_pc + 1) % 64;
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("count", {26'd0, count}, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("wrapped", {31'd0, wrapped}, {31'd0, m_wrap});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        if (m_valid) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", {26'd0, if_pc}, m_ifpc);
        end
    end

    // Apply inputs at a falling edge; return at the next falling edge.
    task automatic cyc(input bit e, input bit s, input bit r, input int p);
        en = e; stall = s; redirect_valid = r; redirect_pc = 6'(p);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h100 + k;
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count", {26'd0, count}, 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", {26'd0, if_pc}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0);
            chk("boot_if_pc", {26'd0, if_pc}, k);
            chk("boot_if_instr", if_instr, 32'h100 + k);
            chk("boot_if_valid", {31'd0, if_valid}, 32'd1);
        end
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0);
            chk("stall_count", {26'd0, count}, 32'd4);
            chk("stall_if_pc", {26'd0, if_pc}, 32'd3);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        cyc(1, 0, 0, 0);
        chk("resume_if_pc", {26'd0, if_pc}, 32'd4);

        cyc(1, 1, 1, 40);
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_count", {26'd0, count}, 32'd40);
        cyc(1, 0, 0, 0);
        chk("redir_if_pc", {26'd0, if_pc}, 32'd40);
        chk("redir_if_valid", {31'd0, if_valid}, 32'd1);

        cyc(1, 0, 1, 62);
        cyc(1, 0, 0, 0);
        chk("wrap62_if_pc", {26'd0, if_pc}, 32'd62);
        chk("wrap62_wrapped", {31'd0, wrapped}, 32'd0);
        cyc(1, 0, 0, 0);
        chk("wrap63_if_pc", {26'd0, if_pc}, 32'd63);
        chk("wrap63_wrapped", {31'd0, wrapped}, 32'd1);
        chk("wrap63_count", {26'd0, count}, 32'd0);
        cyc(1, 0, 0, 0);
        chk("wrap0_if_pc", {26'd0, if_pc}, 32'd0);
        chk("wrap0_wrapped", {31'd0, wrapped}, 32'd0);

        cyc(1, 0, 1, 10);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0);
            chk("en0_valid", {31'd0, if_valid}, 32'd0);
            chk("en0_count", {26'd0, count}, 32'd10);
        end
        cyc(1, 0, 0, 0);
        chk("en1_if_pc", {26'd0, if_pc}, 32'd10);

        cyc(1, 0, 1, 11);
        chk("self_redir_count", {26'd0, count}, 32'd11);
        cyc(1, 0, 0, 0);
        chk("self_redir_if_pc", {26'd0, if_pc}, 32'd11);
        chk("self_redir_instr", if_instr, 32'h10B);

`ifdef FETCH_HALT_EN
        mem[5] = HALT;
        cyc(1, 0, 1, 5);
        cyc(1, 0, 0, 0);
        chk("halt_if_pc", {26'd0, if_pc}, 32'd5);
        chk("halt_valid", {31'd0, if_valid}, 32'd1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        cyc(1, 0, 1, 0);
        chk("halt_count", {26'd0, count}, 32'd5);
        chk("halt_valid2", {31'd0, if_valid}, 32'd0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        mem[5] = 32'h105;
`endif

        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                #1;
                chk("midrst_count", {26'd0, count}, 32'd0);
                chk("midrst_valid", {31'd0, if_valid}, 32'd0);
                chk("midrst_instr", if_instr, NOP);
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, int'($urandom_range(0, 63)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage

`default_nettype wire
